tage_accuracy_monitor: RTL and testbench

//  Synthesisable prediction-accuracy monitor attached beside the TAGE predictor top level.

---
 rtl/tage_stats_pkg.sv | 13 +
 rtl/tage_accuracy_monitor_if.sv | 20 ++
 rtl/tage_stats_fifo.sv | 40 ++++
 rtl/tage_accuracy_monitor.sv | 110 +++++++++++
 tb/tb_tage_accuracy_monitor.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/tage_stats_pkg.sv
// tage_stats_pkg: shared constants, report-entry width helper and saturating increment
package tage_stats_pkg;
   localparam int WIDX_WIDTH_DEF = 16;
   function automatic int rpt_width(input int widx_w, input int win_w);
      return widx_w + win_w;
   endfunction
   // Saturating increment of a w-bit value carried in 64 bits; callers slice the result.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic inc, input int unsigned w);
      logic [63:0] m;
      m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (inc && v != m) ? v + 64'd1 : v;
   endfunction
endpackage

// File: rtl/tage_accuracy_monitor_if.sv
// tage_accuracy_monitor_if: resolve-event input and report valid/ready port
//   master: drives resolve_valid/prediction_correct/provider_id and rpt_ready, receives the report head
//   slave : the monitor side
interface tage_accuracy_monitor_if #(
   parameter int CH_IDX     = 3,
   parameter int WIDX_WIDTH = 16,
   parameter int WIN_WIDTH  = 17
);
   logic                  resolve_valid;
   logic                  prediction_correct;
   logic [CH_IDX-1:0]     provider_id;
   logic                  rpt_valid;
   logic                  rpt_ready;
   logic [WIDX_WIDTH-1:0] rpt_index;
   logic [WIN_WIDTH-1:0]  rpt_correct;
   modport master(output resolve_valid, prediction_correct, provider_id, rpt_ready,
                  input rpt_valid, rpt_index, rpt_correct);
   modport slave(input resolve_valid, prediction_correct, provider_id, rpt_ready,
                 output rpt_valid, rpt_index, rpt_correct);
endinterface

// File: rtl/tage_stats_fifo.sv
// tage_stats_fifo: synchronous FIFO, no fall-through
//   i_clk, i_rst (sync, active-high), i_push/i_din, i_pop, o_dout (head), o_full, o_empty
//   A push while full succeeds only when a pop happens on the same edge; otherwise it is ignored.
module tage_stats_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
)(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr, r_rd;
   logic         w_do_push, w_do_pop;
   always_comb begin
      o_empty   = r_wr == r_rd;
      o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
      w_do_pop  = i_pop & ~o_empty;
      w_do_push = i_push & (~o_full | w_do_pop);
      o_dout    = r_mem[r_rd[AW-1:0]];
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop) r_rd <= r_rd + 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
   end
endmodule

// File: rtl/tage_accuracy_monitor.sv
// tage_accuracy_monitor: cumulative, per-window and per-provider prediction accuracy counters
//   i_clk, i_rst (sync, active-high), i_clear (soft clear, same effect as reset)
//   bus (slave): resolve events in, completed-window reports out over valid/ready
//   o_total_branches/o_correctly_predicted: saturating cumulative counts; o_saturated sticky
//   o_overflow: sticky, a window report was dropped because the FIFO was full
//   i_ch_sel -> o_ch_total/o_ch_correct: registered per-provider readout
module tage_accuracy_monitor
   import tage_stats_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int WINDOW      = 100000,
   parameter int WIN_WIDTH   = $clog2(WINDOW + 1),
   parameter int NUM_CH      = 8,
   parameter int CH_IDX      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int FIFO_DEPTH  = 2,
   parameter int WIDX_WIDTH  = WIDX_WIDTH_DEF
)(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clear,
   tage_accuracy_monitor_if.slave bus,
   output logic [COUNT_WIDTH-1:0] o_total_branches,
   output logic [COUNT_WIDTH-1:0] o_correctly_predicted,
   output logic                   o_saturated,
   output logic                   o_overflow,
   input  logic [CH_IDX-1:0]      i_ch_sel,
   output logic [COUNT_WIDTH-1:0] o_ch_total,
   output logic [COUNT_WIDTH-1:0] o_ch_correct
);
   localparam int RW = rpt_width(WIDX_WIDTH, WIN_WIDTH);
   logic [COUNT_WIDTH-1:0] r_total, r_correct, r_ch_rd_tot, r_ch_rd_cor;
   logic [COUNT_WIDTH-1:0] r_ch_tot [NUM_CH];
   logic [COUNT_WIDTH-1:0] r_ch_cor [NUM_CH];
   logic [WIN_WIDTH-1:0]   r_win_tot, r_win_cor, w_win_tot_inc, w_rpt_cor;
   logic [WIDX_WIDTH-1:0]  r_widx;
   logic                   r_sat, r_ovf;
   logic                   w_clr, w_acc, w_ch_ok, w_sel_ok, w_win_done, w_pop, w_full, w_empty;
   logic [CH_IDX-1:0]      w_id;
   logic [63:0]            w_tot_nxt, w_cor_nxt, w_cht_nxt, w_chc_nxt;
   logic [RW-1:0]          w_head;
   always_comb begin
      w_clr         = i_rst | i_clear;
      w_acc         = bus.resolve_valid & ~w_clr;
      w_ch_ok       = int'(bus.provider_id) < NUM_CH;
      w_id          = w_ch_ok ? bus.provider_id : '0;
      w_sel_ok      = int'(i_ch_sel) < NUM_CH;
      w_tot_nxt     = sat_inc(64'(r_total), 1'b1, COUNT_WIDTH);
      w_cor_nxt     = sat_inc(64'(r_correct), bus.prediction_correct, COUNT_WIDTH);
      w_cht_nxt     = sat_inc(64'(r_ch_tot[w_id]), 1'b1, COUNT_WIDTH);
      w_chc_nxt     = sat_inc(64'(r_ch_cor[w_id]), bus.prediction_correct, COUNT_WIDTH);
      w_win_tot_inc = r_win_tot + 1'b1;
      // The event that completes a window is folded into the pushed report directly.
      w_win_done    = w_acc && (w_win_tot_inc == WIN_WIDTH'(WINDOW));
      w_rpt_cor     = r_win_cor + WIN_WIDTH'(bus.prediction_correct);
      w_pop         = ~w_empty & bus.rpt_ready;
   end
   always_ff @(posedge i_clk) begin
      if (w_clr) begin
         r_total     <= '0;
         r_correct   <= '0;
         r_sat       <= 1'b0;
         r_ovf       <= 1'b0;
         r_win_tot   <= '0;
         r_win_cor   <= '0;
         r_widx      <= '0;
         r_ch_rd_tot <= '0;
         r_ch_rd_cor <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_ch_tot[i] <= '0;
            r_ch_cor[i] <= '0;
         end
      end else begin
         if (w_acc) begin
            r_total   <= w_tot_nxt[COUNT_WIDTH-1:0];
            r_correct <= w_cor_nxt[COUNT_WIDTH-1:0];
            r_sat     <= r_sat | (&w_tot_nxt[COUNT_WIDTH-1:0]) | (&w_cor_nxt[COUNT_WIDTH-1:0]);
            if (w_ch_ok) begin
               r_ch_tot[w_id] <= w_cht_nxt[COUNT_WIDTH-1:0];
               r_ch_cor[w_id] <= w_chc_nxt[COUNT_WIDTH-1:0];
            end
            r_win_tot <= w_win_done ? '0 : w_win_tot_inc;
            r_win_cor <= w_win_done ? '0 : w_rpt_cor;
            // Index advances even when the report is dropped, so consumers see the gap.
            if (w_win_done) r_widx <= r_widx + 1'b1;
         end
         if (w_win_done && w_full && !w_pop) r_ovf <= 1'b1;
         r_ch_rd_tot <= w_sel_ok ? r_ch_tot[i_ch_sel] : '0;
         r_ch_rd_cor <= w_sel_ok ? r_ch_cor[i_ch_sel] : '0;
      end
   end
   tage_stats_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk  (i_clk),
      .i_rst  (w_clr),
      .i_push (w_win_done),
      .i_pop  (w_pop),
      .i_din  ({r_widx, w_rpt_cor}),
      .o_dout (w_head),
      .o_full (w_full),
      .o_empty(w_empty)
   );
   assign bus.rpt_valid         = ~w_empty;
   assign bus.rpt_index         = w_head[RW-1:WIN_WIDTH];
   assign bus.rpt_correct       = w_head[WIN_WIDTH-1:0];
   assign o_total_branches      = r_total;
   assign o_correctly_predicted = r_correct;
   assign o_saturated           = r_sat;
   assign o_overflow            = r_ovf;
   assign o_ch_total            = r_ch_rd_tot;
   assign o_ch_correct          = r_ch_rd_cor;
endmodule

// File: tb/tb_tage_accuracy_monitor.sv
// tb_tage_accuracy_monitor: directed-vector bench, WINDOW=4 instance plus a WINDOW=1 instance
module tb_tage_accuracy_monitor;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear4 = 1'b0, clear1 = 1'b0;
   logic [1:0] ch_sel4 = '0, ch_sel1 = '0;
   logic [7:0] tot4, cor4, cht4, chc4, tot1, cor1, cht1, chc1;
   logic       sat4, ovf4, sat1, ovf1;
   int         n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   tage_accuracy_monitor_if #(.CH_IDX(2), .WIDX_WIDTH(16), .WIN_WIDTH(3)) bus4 ();
   tage_accuracy_monitor_if #(.CH_IDX(2), .WIDX_WIDTH(16), .WIN_WIDTH(1)) bus1 ();
   tage_accuracy_monitor #(.COUNT_WIDTH(8), .WINDOW(4), .WIN_WIDTH(3), .NUM_CH(4), .CH_IDX(2),
                           .FIFO_DEPTH(2), .WIDX_WIDTH(16)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear4), .bus(bus4),
      .o_total_branches(tot4), .o_correctly_predicted(cor4), .o_saturated(sat4), .o_overflow(ovf4),
      .i_ch_sel(ch_sel4), .o_ch_total(cht4), .o_ch_correct(chc4));
   tage_accuracy_monitor #(.COUNT_WIDTH(8), .WINDOW(1), .WIN_WIDTH(1), .NUM_CH(4), .CH_IDX(2),
                           .FIFO_DEPTH(2), .WIDX_WIDTH(16)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear1), .bus(bus1),
      .o_total_branches(tot1), .o_correctly_predicted(cor1), .o_saturated(sat1), .o_overflow(ovf1),
      .i_ch_sel(ch_sel1), .o_ch_total(cht1), .o_ch_correct(chc1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask
   task automatic ev4(input logic c, input logic [1:0] ch);
      bus4.resolve_valid = 1'b1;
      bus4.prediction_correct = c;
      bus4.provider_id = ch;
      step();
      bus4.resolve_valid = 1'b0;
   endtask
   task automatic ev1(input logic c, input logic [1:0] ch);
      bus1.resolve_valid = 1'b1;
      bus1.prediction_correct = c;
      bus1.provider_id = ch;
      step();
      bus1.resolve_valid = 1'b0;
   endtask
   initial begin
      bus4.resolve_valid = 1'b0; bus4.prediction_correct = 1'b0; bus4.provider_id = '0; bus4.rpt_ready = 1'b0;
      bus1.resolve_valid = 1'b0; bus1.prediction_correct = 1'b0; bus1.provider_id = '0; bus1.rpt_ready = 1'b0;
      // 1: basic window and channel readout
      do_reset();
      check("rst_total", 32'(tot4), 0);
      check("rst_correct", 32'(cor4), 0);
      check("rst_valid", 32'(bus4.rpt_valid), 0);
      check("rst_ovf", 32'(ovf4), 0);
      check("rst_sat", 32'(sat4), 0);
      check("rst_chtot", 32'(cht4), 0);
      ch_sel4 = 2'd1;
      ev4(1, 0); ev4(0, 1); ev4(1, 1);
      check("t1_valid_early", 32'(bus4.rpt_valid), 0);
      ev4(1, 2);
      check("t1_total", 32'(tot4), 4);
      check("t1_correct", 32'(cor4), 3);
      check("t1_valid", 32'(bus4.rpt_valid), 1);
      check("t1_idx", 32'(bus4.rpt_index), 0);
      check("t1_rptcor", 32'(bus4.rpt_correct), 3);
      step();
      check("t1_chtot", 32'(cht4), 2);
      check("t1_chcor", 32'(chc4), 1);
      // 2: overflow with consumer stalled, then drain
      do_reset();
      ev4(1, 0); ev4(1, 0); ev4(0, 0); ev4(0, 0);
      ev4(1, 0); ev4(1, 0); ev4(1, 0); ev4(0, 0);
      check("t2_ovf_before", 32'(ovf4), 0);
      ev4(1, 0); ev4(1, 0); ev4(1, 0); ev4(1, 0);
      check("t2_ovf", 32'(ovf4), 1);
      check("t2_head0_idx", 32'(bus4.rpt_index), 0);
      check("t2_head0_cor", 32'(bus4.rpt_correct), 2);
      bus4.rpt_ready = 1'b1;
      step();
      check("t2_head1_idx", 32'(bus4.rpt_index), 1);
      check("t2_head1_cor", 32'(bus4.rpt_correct), 3);
      step();
      bus4.rpt_ready = 1'b0;
      check("t2_drained", 32'(bus4.rpt_valid), 0);
      ev4(0, 0); ev4(0, 0); ev4(0, 0); ev4(1, 0);
      check("t2_gap_idx", 32'(bus4.rpt_index), 3);
      check("t2_gap_cor", 32'(bus4.rpt_correct), 1);
      check("t2_ovf_sticky", 32'(ovf4), 1);
      check("t2_total", 32'(tot4), 16);
      check("t2_correct", 32'(cor4), 10);
      // 3: push and pop on the same edge while full
      do_reset();
      ev4(1, 0); ev4(0, 0); ev4(0, 0); ev4(0, 0);
      ev4(0, 0); ev4(1, 0); ev4(1, 0); ev4(0, 0);
      ev4(1, 0); ev4(1, 0); ev4(1, 0);
      bus4.rpt_ready = 1'b1;
      ev4(1, 0);
      bus4.rpt_ready = 1'b0;
      check("t3_ovf", 32'(ovf4), 0);
      check("t3_head_idx", 32'(bus4.rpt_index), 1);
      check("t3_head_cor", 32'(bus4.rpt_correct), 2);
      bus4.rpt_ready = 1'b1;
      step();
      check("t3_next_idx", 32'(bus4.rpt_index), 2);
      check("t3_next_cor", 32'(bus4.rpt_correct), 4);
      step();
      bus4.rpt_ready = 1'b0;
      check("t3_drained", 32'(bus4.rpt_valid), 0);
      // 4: saturation of cumulative and channel counters
      do_reset();
      ch_sel4 = 2'd0;
      bus4.rpt_ready = 1'b1;
      for (int i = 0; i < 254; i++) ev4(1, 0);
      check("t4_total_254", 32'(tot4), 254);
      check("t4_sat_254", 32'(sat4), 0);
      for (int i = 0; i < 46; i++) ev4(1, 0);
      check("t4_total", 32'(tot4), 255);
      check("t4_correct", 32'(cor4), 255);
      check("t4_sat", 32'(sat4), 1);
      check("t4_ovf", 32'(ovf4), 0);
      check("t4_valid", 32'(bus4.rpt_valid), 1);
      check("t4_idx", 32'(bus4.rpt_index), 74);
      check("t4_rptcor", 32'(bus4.rpt_correct), 4);
      step();
      bus4.rpt_ready = 1'b0;
      check("t4_chtot", 32'(cht4), 255);
      // 5: clear mid-window beats a concurrent event
      do_reset();
      ev4(1, 0); ev4(1, 0); ev4(1, 0); ev4(1, 0);
      ev4(1, 0); ev4(1, 0);
      check("t5_pre_valid", 32'(bus4.rpt_valid), 1);
      check("t5_pre_chtot", 32'(cht4), 5);
      clear4 = 1'b1;
      bus4.resolve_valid = 1'b1; bus4.prediction_correct = 1'b1; bus4.provider_id = 2'd0;
      step();
      clear4 = 1'b0;
      bus4.resolve_valid = 1'b0;
      check("t5_total", 32'(tot4), 0);
      check("t5_correct", 32'(cor4), 0);
      check("t5_valid", 32'(bus4.rpt_valid), 0);
      check("t5_chtot", 32'(cht4), 0);
      ev4(1, 0); ev4(1, 0); ev4(0, 0); ev4(1, 0);
      check("t5_idx", 32'(bus4.rpt_index), 0);
      check("t5_rptcor", 32'(bus4.rpt_correct), 3);
      check("t5_total_after", 32'(tot4), 4);
      // 6: WINDOW=1 and channel 3 readout latency
      do_reset();
      ch_sel1 = 2'd3;
      bus1.rpt_ready = 1'b1;
      ev1(1, 3);
      check("t6_v0", 32'(bus1.rpt_valid), 1);
      check("t6_idx0", 32'(bus1.rpt_index), 0);
      check("t6_cor0", 32'(bus1.rpt_correct), 1);
      ev1(0, 3);
      check("t6_idx1", 32'(bus1.rpt_index), 1);
      check("t6_cor1", 32'(bus1.rpt_correct), 0);
      ev1(1, 3);
      check("t6_idx2", 32'(bus1.rpt_index), 2);
      check("t6_cor2", 32'(bus1.rpt_correct), 1);
      check("t6_chtot_lag", 32'(cht1), 2);
      step();
      check("t6_chtot", 32'(cht1), 3);
      check("t6_chcor", 32'(chc1), 2);
      check("t6_total", 32'(tot1), 3);
      check("t6_drained", 32'(bus1.rpt_valid), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
